// File: rtl/rc4_crack_pkg.sv
// Shared types for the RC4 key-search datapath: key width and the
// result-collector state encoding.
package rc4_crack_pkg;

    localparam int KEY_WIDTH = 22;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2,
        FAILED = 2'd3
    } collector_state_t;

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of vec,
// with valid=0 (and idx=0) when no bit is set.
module lowest_set_index #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scanning from the top lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_result_collector.sv
// Collects found/exhausted flags from the cracking cores, latches the first
// winning key, broadcasts a registered stop_all and drives the HEX display.
module key_result_collector #(
    parameter int CORE_COUNT  = 4,
    parameter int KEY_WIDTH   = rc4_crack_pkg::KEY_WIDTH,
    parameter int ROTATE_LOG2 = 24,
    localparam int IDX_W      = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CORE_COUNT*KEY_WIDTH-1:0] core_key,
    input  logic [CORE_COUNT-1:0]           core_found,
    input  logic [CORE_COUNT-1:0]           core_exhausted,
    input  logic                            show_live,
    output logic                            stop_all,
    output logic                            found,
    output logic                            failed,
    output logic [KEY_WIDTH-1:0]            winner_key,
    output logic [IDX_W-1:0]                winner_core,
    output logic [KEY_WIDTH-1:0]            display,
    output logic [31:0]                     search_cycles,
    output rc4_crack_pkg::collector_state_t dbg_state
);

    import rc4_crack_pkg::*;

    collector_state_t        state, state_next;
    logic [KEY_WIDTH-1:0]    keys [CORE_COUNT];
    logic [KEY_WIDTH-1:0]    key_or;
    logic [IDX_W-1:0]        win_idx;
    logic                    any_found;
    logic                    win_now;
    logic [KEY_WIDTH-1:0]    winner_key_next;
    logic [KEY_WIDTH-1:0]    display_next;
    logic [IDX_W-1:0]        live_idx;
    logic [ROTATE_LOG2-1:0]  dwell;

    assign dbg_state = state;

    lowest_set_index #(.N(CORE_COUNT), .IDX_W(IDX_W)) u_win_enc (
        .vec   (core_found),
        .idx   (win_idx),
        .valid (any_found)
    );

    always_comb begin
        key_or = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            keys[i] = core_key[i*KEY_WIDTH +: KEY_WIDTH];
            key_or  = key_or | keys[i];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SEARCH;
            SEARCH: begin
                // A find beats exhaustion seen on the same edge.
                if (any_found)            state_next = FOUND;
                else if (&core_exhausted) state_next = FAILED;
            end
            default: state_next = state;
        endcase
    end

    assign win_now         = (state == SEARCH) && any_found;
    assign winner_key_next = win_now ? keys[win_idx] : winner_key;

    always_comb begin
        display_next = '0;
        case (state_next)
            SEARCH:  display_next = show_live ? keys[live_idx] : key_or;
            FOUND:   display_next = winner_key_next;
            FAILED:  display_next = '1;
            default: display_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            found         <= 1'b0;
            failed        <= 1'b0;
            stop_all      <= 1'b0;
            winner_key    <= '0;
            winner_core   <= '0;
            display       <= '0;
            search_cycles <= '0;
            live_idx      <= '0;
            dwell         <= '0;
        end else begin
            state    <= state_next;
            found    <= (state_next == FOUND);
            failed   <= (state_next == FAILED);
            stop_all <= (state_next == FOUND) || (state_next == FAILED);
            display  <= display_next;
            if (win_now) begin
                winner_key  <= winner_key_next;
                winner_core <= win_idx;
            end
            if (state == SEARCH) begin
                if (search_cycles != 32'hFFFF_FFFF) search_cycles <= search_cycles + 32'd1;
                dwell <= dwell + 1'b1;
                if (&dwell) begin
                    live_idx <= (live_idx == IDX_W'(CORE_COUNT - 1)) ? '0 : live_idx + 1'b1;
                end
            end
        end
    end

endmodule
